// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: two-digit common-anode 7-seg scanner with per-slot blanking.
// Ports: clk, rst_n (sync low), seg_u/seg_d codes in; an, seg, dp, frame_tick out.
module seg7_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_u,
  input  logic [6:0] seg_d,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

  typedef enum logic {
    UNITS = 1'b0,
    TENS  = 1'b1
  } digit_e;

  logic [CW-1:0] cnt_q, cnt_d;
  digit_e        digit_q, digit_d;
  logic [6:0]    sh_units_q, sh_units_d;
  logic [6:0]    sh_tens_q, sh_tens_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    sb_q, sb_d;
  logic          ft_q, ft_d;
  logic          wrap;
  logic          cap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      digit_q    <= UNITS;
      sh_units_q <= 7'h7F;
      sh_tens_q  <= 7'h7F;
      an_q       <= 4'b1111;
      sb_q       <= 7'h7F;
      ft_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      sh_units_q <= sh_units_d;
      sh_tens_q  <= sh_tens_d;
      an_q       <= an_d;
      sb_q       <= sb_d;
      ft_q       <= ft_d;
    end
  end

  // Shadows load only at the first cycle of a frame so a
  // digit never changes mid-scan.
  always_comb begin
    wrap       = (cnt_q == LAST);
    cap        = (cnt_q == '0) && (digit_q == UNITS);
    cnt_d      = wrap ? '0 : cnt_q + CW'(1);
    digit_d    = digit_q;
    if (wrap) begin
      digit_d = (digit_q == UNITS) ? TENS : UNITS;
    end
    sh_units_d = cap ? seg_u : sh_units_q;
    sh_tens_d  = cap ? seg_d : sh_tens_q;
    ft_d       = cap;
  end

  // Leading part of every slot is dead time with all anodes off.
  always_comb begin
    an_d = 4'b1111;
    sb_d = 7'h7F;
    if (cnt_q >= BLK) begin
      unique case (digit_q)
        UNITS: begin
          an_d = 4'b1110;
          sb_d = sh_units_q;
        end
        TENS: begin
          an_d = 4'b1101;
          sb_d = sh_tens_q;
        end
      endcase
    end
  end

  assign an         = an_q;
  assign seg        = sb_q;
  assign dp         = 1'b1;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed bench for seg7_scan_mux, REFRESH_DIV=8 BLANK_CYC=2.
// Slot-position model keyed on frame_tick plus hand-computed directed checks.
module tb_seg7_scan_mux;

  localparam int R = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_u;
  logic [6:0] seg_d;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int nchk = 0;
  int nerr = 0;

  bit         have_ft = 1'b0;
  int         since = 0;
  logic [6:0] exp_u = 7'h7F;
  logic [6:0] exp_d = 7'h7F;

  seg7_scan_mux #(
    .REFRESH_DIV(R),
    .BLANK_CYC  (B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_u     (seg_u),
    .seg_d     (seg_d),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    nchk++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // One cycle: sample at the falling edge and compare with the
  // slot-position model (position counted from the last frame_tick).
  task automatic step();
    logic [3:0] ean;
    logic [6:0] eseg;
    int         p;
    @(negedge clk);
    if (frame_tick === 1'b1) begin
      if (have_ft) chk("ft_period", since + 1, 2 * R);
      have_ft = 1'b1;
      since   = 0;
      exp_u   = seg_u;
      exp_d   = seg_d;
    end else if (have_ft) begin
      since++;
    end
    ean  = 4'b1111;
    eseg = 7'h7F;
    if (have_ft) begin
      p = since % (2 * R);
      if (p >= B && p < R) begin
        ean  = 4'b1110;
        eseg = exp_u;
      end else if (p >= R + B) begin
        ean  = 4'b1101;
        eseg = exp_d;
      end
    end else begin
      chk("ft_idle", frame_tick, 0);
    end
    chk("an", an, ean);
    chk("seg", seg, eseg);
    chk("dp", dp, 1);
    chk("an_hi", an[3:2], 2'b11);
    chk("an_onelow", ($countones(~an) <= 1), 1);
  endtask

  task automatic run_to(input int k);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(have_ft && since == k) && n < 40);
    if (!(have_ft && since == k)) chk("run_to_timeout", since, k);
  endtask

  task automatic wait_ft(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    seg_u = 7'h15;
    seg_d = 7'h2A;

    // reset hold with arbitrary inputs
    repeat (3) begin
      step();
      seg_u = 7'($urandom);
      seg_d = 7'($urandom);
    end
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_ft", frame_tick, 0);

    // basic scan
    seg_u = 7'b1000000;
    seg_d = 7'b1111001;
    rst_n = 1'b1;
    wait_ft(lat);
    chk("ft_after_e1", lat, 1);
    step();
    chk("blank_u1", an, 4'b1111);
    step();
    chk("drive_u_an", an, 4'b1110);
    chk("drive_u_seg", seg, 7'b1000000);
    run_to(R - 1);
    chk("drive_u_last", an, 4'b1110);
    step();
    chk("blank_t", an, 4'b1111);
    run_to(R + B);
    chk("drive_t_an", an, 4'b1101);
    chk("drive_t_seg", seg, 7'b1111001);
    run_to(0);

    // mid-frame change while cnt=4, UNITS
    run_to(3);
    seg_u = 7'b0100100;
    run_to(5);
    chk("mid_u_an", an, 4'b1110);
    chk("mid_u_seg", seg, 7'b1000000);
    run_to(12);
    chk("mid_t_an", an, 4'b1101);
    chk("mid_t_seg", seg, 7'b1111001);
    seg_d = 7'b1111111;
    run_to(2);
    chk("new_u_an", an, 4'b1110);
    chk("new_u_seg", seg, 7'b0100100);

    // blank tens still enables its anode
    run_to(12);
    chk("blank_t_an", an, 4'b1101);
    chk("blank_t_seg", seg, 7'h7F);

    // reset mid-drive
    rst_n   = 1'b0;
    have_ft = 1'b0;
    step();
    chk("rst_mid_an", an, 4'b1111);
    chk("rst_mid_seg", seg, 7'h7F);
    chk("rst_mid_ft", frame_tick, 0);
    rst_n = 1'b1;
    wait_ft(lat);
    chk("ft_after_rel", lat, 1);
    run_to(2);
    chk("rel_u_an", an, 4'b1110);
    chk("rel_u_seg", seg, 7'b0100100);

    // long random run
    for (int i = 0; i < 1000; i++) begin
      step();
      if ($urandom_range(0, 4) == 0) seg_u = 7'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        seg_d = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed driver for the two-digit common-anode 7-segment display. It sits directly downstream of the units and tens binary-to-7-segment decoders and consumes their registered active-low segment codes. It drives the shared segment bus and the anode lines one digit at a time, inserting a blanking interval before each digit to prevent ghosting. Segment codes are captured once per frame so a digit never changes partway through a scan.

## Interface
- REFRESH_DIV, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Must be ≥ 2.
- BLANK_CYC, default 1000: dead-time cycles at the start of each slot with all anodes off. Must satisfy 1 ≤ BLANK_CYC < REFRESH_DIV.
- clk, in, 1: single system clock; all state updates on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- seg_u, in, 7: units digit code, ABC_DEFG order, active-low. Comes from the units decoder.
- seg_d, in, 7: tens digit code, ABC_DEFG order, active-low. Comes from the tens decoder; 7'b1111111 means blank.
- an, out, 4: anode enables, active-low.
  - an[0] is units.
  - an[1] is tens.
  - an[3:2] are held at 1.
- seg, out, 7: shared segment bus, active-low, ABC_DEFG order.
- dp, out, 1: decimal point, active-low. Tied to 1.
- frame_tick, out, 1: one-cycle pulse marking the start of each frame and each shadow capture.

## Operation
- State registers:
  - cnt: slot counter, 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - digit: slot select, UNITS=0 or TENS=1.
  - sh_u, sh_d: 7-bit shadow registers.
- Phase is decoded from cnt:
  - BLANK when cnt < BLANK_CYC.
  - DRIVE otherwise.
- Each edge with rst_n=1:
  - cnt increments.
  - At cnt==REFRESH_DIV-1, cnt wraps to 0 and digit toggles.
  - Scan order: UNITS then TENS, repeating. One frame = 2·REFRESH_DIV cycles.
- Shadow capture: at the edge that ends a cycle in which (cnt==0, digit==UNITS), sh_u←seg_u and sh_d←seg_d. The inputs are sampled at no other time.
- Output register, computed from the current (cnt, digit):
  - BLANK: an=4'b1111, seg=7'b1111111.
  - DRIVE, UNITS: an=4'b1110, seg=sh_u.
  - DRIVE, TENS: an=4'b1101, seg=sh_d.
- frame_tick is registered and goes high for exactly one cycle after each shadow capture edge.
- A blank tens code (7'b1111111) is displayed as-is: the anode is still enabled and all segments are off. No leading-zero logic lives in this block.
- At most one anode is low in any cycle. an and seg change on the same edge.
- Synchronous reset (rst_n=0 at an edge), including mid-frame:
  - cnt=0, digit=UNITS.
  - sh_u = sh_d = 7'b1111111.
  - an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
  - The scan restarts from the UNITS BLANK phase.

## Timing
- Reset values of every output: an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
- Edge E1 is the first edge with rst_n=1. At E1:
  - State (0, UNITS) is sampled, so the shadows capture.
  - frame_tick=1 for the following cycle.
  - Outputs show BLANK.
- Outputs lag (cnt, digit) by one cycle.
  - With BLANK_CYC=b and REFRESH_DIV=r: after E1, outputs are blank for b cycles, then drive UNITS for r−b cycles.
  - Then TENS: b blank cycles, then r−b drive cycles.
  - Then the next frame_tick; frame_tick period is 2r cycles.
- Input-to-display latency: from a change on seg_u/seg_d to its appearance is at least BLANK_CYC+1 cycles and at most 2·REFRESH_DIV+BLANK_CYC cycles. It is always aligned to a frame start.
- Reset has priority over the counter wrap and over shadow capture when they fall on the same edge.

## Test plan
(Parameters for all scenarios: REFRESH_DIV=8, BLANK_CYC=2.)
- Reset hold: rst_n=0 for 3 edges with arbitrary inputs -> an=4'b1111, seg=7'h7F, dp=1, frame_tick=0 throughout.
- Basic scan: seg_u=7'b1000000, seg_d=7'b1111001, release reset ->
  - frame_tick=1 in the cycle after E1.
  - 2 cycles blank, then an=4'b1110 / seg=7'b1000000 for 6 cycles.
  - 2 cycles blank, then an=4'b1101 / seg=7'b1111001 for 6 cycles.
  - Next frame_tick exactly 16 cycles after the first.
- Mid-frame input change: set seg_u=7'b0100100 while cnt=4, digit=UNITS -> the current and next TENS slot are unchanged, and an=4'b1110 keeps seg=7'b1000000. The new code appears only in the UNITS DRIVE phase after the next frame_tick.
- Blank tens: seg_d=7'b1111111, seg_u=7'b0100100 -> the TENS slot shows an=4'b1101 with seg=7'b1111111, and the UNITS slot shows seg=7'b0100100.
- Reset mid-drive: assert rst_n=0 while an=4'b1101 -> next edge an=4'b1111, seg=7'h7F. After release, the first frame_tick and UNITS drive follow the basic-scan timing exactly.
- Long run of 1000 cycles with random input changes, checking continuously:
  - an never has two bits low.
  - an[3:2]=2'b11 and dp=1.
  - frame_tick period is 16.
  - seg equals the code captured at the last frame_tick for the active digit.
